// File: rtl/pcm_audio_pkg.sv
// ----------------------------------------------------------------------------
// pcm_audio_pkg
// Shared definitions for the PDM microphone capture path that feeds the audio
// capture FIFO.
//   cap_state_t : capture FSM encoding (IDLE / WARMUP / RUN), 2 bits
//   PCM_W       : PCM sample width, matches the FIFO din width
//   satMax()    : largest unsigned value representable in a given width
// ----------------------------------------------------------------------------
package pcm_audio_pkg;

    localparam int PCM_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } cap_state_t;

    // All-ones value of a width-bit unsigned number; used as the clamp value
    // when a frame is entirely ones and the count overflows the sample width.
    function automatic int satMax(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// ----------------------------------------------------------------------------
// pdm_clk_gen
// Divides clk down to the microphone clock and marks the cycle in which the
// microphone data bit should be captured.
// Ports:
//   clk           in  system clock
//   reset         in  synchronous, active-high reset
//   i_run         in  1 = clock running; 0 = divider and mic clock held at 0
//   o_mic_clk     out clock driven to the microphone, period 2*CLK_DIV clk
//   o_sample_tick out one-cycle strobe in the last clk cycle of the high phase
// ----------------------------------------------------------------------------
module pdm_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_mic_clk,
    output logic o_sample_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_mic_clk;
    logic             w_terminal;

    assign w_terminal = (r_div == DIV_LAST);

    // Holding the divider at 0 while stopped guarantees that every start
    // begins with a full low phase, so the first high phase always starts
    // exactly CLK_DIV cycles after i_run rises.
    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_div     <= '0;
            r_mic_clk <= 1'b0;
        end else if (w_terminal) begin
            r_div     <= '0;
            r_mic_clk <= ~r_mic_clk;
        end else begin
            r_div     <= r_div + DIV_W'(1);
        end
    end

    // The microphone data is most settled at the end of the high phase, just
    // before mic_clk falls.
    assign o_sample_tick = i_run && w_terminal && r_mic_clk;
    assign o_mic_clk     = r_mic_clk;

endmodule

// File: rtl/pdm_mic_capture.sv
// ----------------------------------------------------------------------------
// pdm_mic_capture
// Clocks a PDM MEMS microphone, counts the ones in every frame of DECIM bits
// and pushes the resulting PCM sample into the audio capture FIFO.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high reset
//   en          in  capture enable (level)
//   mic_data    in  PDM bit, already synchronised to clk
//   full        in  FIFO full flag
//   mic_clk     out clock to the microphone
//   dout        out PCM sample (FIFO din)
//   wr          out one-cycle FIFO write strobe
//   overrun     out sticky: a sample was dropped because the FIFO was full
//   overrun_cnt out saturating count of dropped samples
// ----------------------------------------------------------------------------
module pdm_mic_capture
    import pcm_audio_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int DECIM         = 256,
    parameter int DATA_WIDTH    = PCM_W,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mic_data,
    input  logic                  full,
    output logic                  mic_clk,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  wr,
    output logic                  overrun,
    output logic [7:0]            overrun_cnt
);

    localparam int WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] BIT_LAST = DATA_WIDTH'(DECIM - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_VAL  = DATA_WIDTH'(satMax(DATA_WIDTH));

    cap_state_t            r_state;
    cap_state_t            w_next_state;
    logic [DATA_WIDTH:0]   r_acc;
    logic [DATA_WIDTH-1:0] r_bit_cnt;
    logic [WARM_W-1:0]     r_warm_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_wr;
    logic                  r_overrun;
    logic [7:0]            r_overrun_cnt;

    logic                  w_active;
    logic                  w_tick;
    logic                  w_mic_clk;
    logic                  w_frame_end;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sample;

    // Dropping en takes effect in the same cycle, so the clock stops and no
    // sample of the partial frame is taken on the edge that leaves for IDLE.
    assign w_active = (r_state != IDLE) && en;

    pdm_clk_gen #(
        .CLK_DIV       (CLK_DIV)
    ) u_clk_gen (
        .clk           (clk),
        .reset         (reset),
        .i_run         (w_active),
        .o_mic_clk     (w_mic_clk),
        .o_sample_tick (w_tick)
    );

    // The final bit of a frame is folded in combinationally so the frame can
    // be closed and the accumulator restarted in the same cycle. Only an
    // all-ones frame reaches 2**DATA_WIDTH, which is clamped to all ones.
    assign w_frame_end = w_tick && (r_bit_cnt == BIT_LAST);
    assign w_sum       = r_acc + {{DATA_WIDTH{1'b0}}, mic_data};
    assign w_sample    = w_sum[DATA_WIDTH] ? SAT_VAL : w_sum[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Warm-up frames give the microphone time to settle; with no warm-up
    // configured, capture goes straight to RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                if (!en) begin
                    w_next_state = IDLE;
                end else if (w_frame_end && (r_warm_cnt == WARM_LAST)) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Accumulation and FIFO handshake. overrun/overrun_cnt survive en=0 so
    // software can still read them after stopping capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_bit_cnt     <= '0;
            r_warm_cnt    <= '0;
            r_dout        <= '0;
            r_wr          <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else begin
            r_wr <= 1'b0;
            if (!w_active) begin
                r_acc      <= '0;
                r_bit_cnt  <= '0;
                r_warm_cnt <= '0;
            end else if (w_tick) begin
                if (w_frame_end) begin
                    r_acc     <= '0;
                    r_bit_cnt <= '0;
                    if (r_state == WARMUP) begin
                        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                    end
                    if (r_state == RUN) begin
                        r_dout <= w_sample;
                        if (!full) begin
                            r_wr <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                            if (r_overrun_cnt != 8'hFF) begin
                                r_overrun_cnt <= r_overrun_cnt + 8'd1;
                            end
                        end
                    end
                end else begin
                    r_acc     <= w_sum;
                    r_bit_cnt <= r_bit_cnt + DATA_WIDTH'(1);
                end
            end
        end
    end

    assign mic_clk     = w_mic_clk;
    assign dout        = r_dout;
    assign wr          = r_wr;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// ----------------------------------------------------------------------------
// tb_pdm_mic_capture
// Directed bench for pdm_mic_capture. The main instance uses the default
// parameters; a second, small instance (4-bit samples, 16-bit frames,
// CLK_DIV=1, no warm-up) makes the 300-frame overrun saturation affordable.
// A microphone model presents a new bit on every rising mic_clk, choosing it
// from the current pattern and the bit position within the frame.
// ----------------------------------------------------------------------------
module tb_pdm_mic_capture;

    logic       clk;
    logic       reset;
    logic       en;
    logic       micData;
    logic       full;
    logic       micClk;
    logic [7:0] dout;
    logic       wr;
    logic       overrun;
    logic [7:0] overrunCnt;

    logic       sEn;
    logic       sMicData;
    logic       sFull;
    logic       sMicClk;
    logic [3:0] sDout;
    logic       sWr;
    logic       sOverrun;
    logic [7:0] sOverrunCnt;

    int checks = 0;
    int passes = 0;

    // Pattern: 0 all zeros, 1 all ones, 2 alternating 1/0, 3 ramp (64 ones)
    int   patMode = 0;
    int   bitIdx  = 0;
    logic prevMic = 1'b0;

    pdm_mic_capture #(
        .CLK_DIV       (2),
        .DECIM         (256),
        .DATA_WIDTH    (8),
        .WARMUP_FRAMES (2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mic_data    (micData),
        .full        (full),
        .mic_clk     (micClk),
        .dout        (dout),
        .wr          (wr),
        .overrun     (overrun),
        .overrun_cnt (overrunCnt)
    );

    pdm_mic_capture #(
        .CLK_DIV       (1),
        .DECIM         (16),
        .DATA_WIDTH    (4),
        .WARMUP_FRAMES (0)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .en          (sEn),
        .mic_data    (sMicData),
        .full        (sFull),
        .mic_clk     (sMicClk),
        .dout        (sDout),
        .wr          (sWr),
        .overrun     (sOverrun),
        .overrun_cnt (sOverrunCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic patBit(input int mode, input int idx);
        case (mode)
            1:       return 1'b1;
            2:       return (idx % 2) == 0;
            3:       return idx < 64;
            default: return 1'b0;
        endcase
    endfunction

    // Microphone model: bit position restarts whenever the capture block is
    // stopped or reset, since a fresh start always begins on frame bit 0.
    initial micData = 1'b0;
    always @(negedge clk) begin
        #1;
        if (reset || !en) begin
            bitIdx = 0;
        end else if (micClk && !prevMic) begin
            micData = patBit(patMode, bitIdx);
            bitIdx  = (bitIdx + 1) % 256;
        end
        prevMic = micClk;
    end

    // Advances until wr is seen at a falling edge; n is the number of rising
    // edges taken.
    task automatic waitWr(input int maxCycles, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < maxCycles) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wr === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        en       = 1'b0;
        full     = 1'b0;
        sEn      = 1'b0;
        sFull    = 1'b0;
        sMicData = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (micClk !== 1'b0) $display("[TB] FAIL reset_mic_clk: got %b expected 0", micClk); else passes++;
        checks++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", dout); else passes++;
        checks++; if (wr !== 1'b0) $display("[TB] FAIL reset_wr: got %b expected 0", wr); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (overrunCnt !== 8'd0) $display("[TB] FAIL reset_overrun_cnt: got %0d expected 0", overrunCnt); else passes++;
        checks++; if (sDout !== 4'h0) $display("[TB] FAIL reset_small_dout: got %h expected 0", sDout); else passes++;
        reset = 1'b0;
    endtask

    // No warm-up: RUN starts one edge after en; the 16th sample lands in
    // cycle 31 of RUN, so wr is seen after 33 rising edges.
    task automatic test_small_saturation();
        int  n;
        int  wrCount;
        bit  seen;
        sEn  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sWr === 1'b1) seen = 1'b1;
        end
        checks++; if (n !== 33) $display("[TB] FAIL small_first_wr: got %0d cycles expected 33", n); else passes++;
        checks++; if (sDout !== 4'hF) $display("[TB] FAIL small_all_ones_sat: got %h expected f", sDout); else passes++;
        sFull   = 1'b1;
        wrCount = 0;
        for (int i = 0; i < 300 * 32 + 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sWr !== 1'b0) wrCount++;
        end
        checks++; if (wrCount !== 0) $display("[TB] FAIL small_wr_while_full: got %0d pulses expected 0", wrCount); else passes++;
        checks++; if (sOverrun !== 1'b1) $display("[TB] FAIL small_overrun: got %b expected 1", sOverrun); else passes++;
        checks++; if (sOverrunCnt !== 8'd255) $display("[TB] FAIL small_overrun_cnt_sat: got %0d expected 255", sOverrunCnt); else passes++;
        sEn   = 1'b0;
        sFull = 1'b0;
    endtask

    // WARMUP starts at the first edge after en; mic_clk is high in warm-up
    // cycles 2,3 mod 4; frames end in cycles 1023, 2047, 3071, so the first
    // wr appears at rising edge 3073.
    task automatic test_ones_warmup();
        int   n;
        int   badCycle;
        bit   seen;
        logic expMic;
        patMode  = 1;
        en       = 1'b1;
        n        = 0;
        seen     = 1'b0;
        badCycle = -1;
        while (!seen && n < 4000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            expMic = (((n - 1) / 2) % 2) == 1;
            if (badCycle < 0 && micClk !== expMic) badCycle = n;
            if (wr === 1'b1) seen = 1'b1;
        end
        checks++; if (n !== 3073) $display("[TB] FAIL first_wr_latency: got %0d cycles expected 3073", n); else passes++;
        checks++; if (badCycle !== -1) $display("[TB] FAIL mic_clk_period: got deviation at cycle %0d expected none", badCycle); else passes++;
        checks++; if (dout !== 8'hFF) $display("[TB] FAIL ones_dout: got %h expected ff", dout); else passes++;
        waitWr(1100, n, seen);
        checks++; if (n !== 1024) $display("[TB] FAIL ones_wr_spacing: got %0d cycles expected 1024", n); else passes++;
        checks++; if (dout !== 8'hFF) $display("[TB] FAIL ones_dout_2: got %h expected ff", dout); else passes++;
    endtask

    task automatic test_patterns();
        int         n;
        bit         seen;
        int         modes [3]   = '{0, 2, 3};
        logic [7:0] expect_ [3] = '{8'h00, 8'h80, 8'h40};
        for (int k = 0; k < 3; k++) begin
            patMode = modes[k];
            waitWr(1100, n, seen);
            checks++; if (n !== 1024) $display("[TB] FAIL pattern%0d_spacing: got %0d cycles expected 1024", modes[k], n); else passes++;
            checks++; if (dout !== expect_[k]) $display("[TB] FAIL pattern%0d_dout: got %h expected %h", modes[k], dout, expect_[k]); else passes++;
        end
    endtask

    task automatic test_ramp_stable();
        int n;
        bit seen;
        bit unstable;
        n        = 0;
        seen     = 1'b0;
        unstable = 1'b0;
        while (!seen && n < 1100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wr === 1'b1) seen = 1'b1;
            else if (dout !== 8'h40) unstable = 1'b1;
        end
        checks++; if (n !== 1024) $display("[TB] FAIL ramp_wr_width_spacing: got %0d cycles expected 1024", n); else passes++;
        checks++; if (unstable !== 1'b0) $display("[TB] FAIL ramp_dout_stable: got change %b expected 0", unstable); else passes++;
        checks++; if (dout !== 8'h40) $display("[TB] FAIL ramp_dout: got %h expected 40", dout); else passes++;
    endtask

    // Starts one cycle after a wr; the next three frame ends fall within the
    // following 3172 cycles and the fourth 924 cycles after that.
    task automatic test_overrun();
        int n;
        int wrCount;
        bit seen;
        full    = 1'b1;
        patMode = 1;
        wrCount = 0;
        for (int i = 0; i < 3172; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr !== 1'b0) wrCount++;
        end
        checks++; if (wrCount !== 0) $display("[TB] FAIL wr_while_full: got %0d pulses expected 0", wrCount); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL overrun_set: got %b expected 1", overrun); else passes++;
        checks++; if (overrunCnt !== 8'd3) $display("[TB] FAIL overrun_cnt_3: got %0d expected 3", overrunCnt); else passes++;
        checks++; if (dout !== 8'hFF) $display("[TB] FAIL dout_updates_when_full: got %h expected ff", dout); else passes++;
        full = 1'b0;
        waitWr(1100, n, seen);
        checks++; if (n !== 924) $display("[TB] FAIL wr_after_full_drop: got %0d cycles expected 924", n); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); else passes++;
        checks++; if (overrunCnt !== 8'd3) $display("[TB] FAIL overrun_cnt_hold: got %0d expected 3", overrunCnt); else passes++;
    endtask

    task automatic test_abort();
        int n;
        int wrCount;
        bit seen;
        patMode = 3;
        repeat (512) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (micClk !== 1'b0) $display("[TB] FAIL abort_mic_clk: got %b expected 0", micClk); else passes++;
        wrCount = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr !== 1'b0 || micClk !== 1'b0) wrCount++;
        end
        checks++; if (wrCount !== 0) $display("[TB] FAIL abort_idle_quiet: got %0d active cycles expected 0", wrCount); else passes++;
        checks++; if (overrunCnt !== 8'd3) $display("[TB] FAIL abort_cnt_kept: got %0d expected 3", overrunCnt); else passes++;
        en = 1'b1;
        waitWr(4000, n, seen);
        checks++; if (n !== 3073) $display("[TB] FAIL restart_latency: got %0d cycles expected 3073", n); else passes++;
        checks++; if (dout !== 8'h40) $display("[TB] FAIL restart_dout: got %h expected 40", dout); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL abort_overrun_kept: got %b expected 1", overrun); else passes++;
    endtask

    task automatic test_reset_midframe();
        int n;
        bit seen;
        repeat (500) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (micClk !== 1'b0) $display("[TB] FAIL midreset_mic_clk: got %b expected 0", micClk); else passes++;
        checks++; if (dout !== 8'h00) $display("[TB] FAIL midreset_dout: got %h expected 00", dout); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL midreset_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (overrunCnt !== 8'd0) $display("[TB] FAIL midreset_overrun_cnt: got %0d expected 0", overrunCnt); else passes++;
        reset = 1'b0;
        waitWr(4000, n, seen);
        checks++; if (n !== 3073) $display("[TB] FAIL midreset_restart: got %0d cycles expected 3073", n); else passes++;
        checks++; if (dout !== 8'h40) $display("[TB] FAIL midreset_dout_after: got %h expected 40", dout); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL midreset_overrun_after: got %b expected 0", overrun); else passes++;
    endtask

    initial begin
        test_reset();
        test_small_saturation();
        test_ones_warmup();
        test_patterns();
        test_ramp_stable();
        test_overrun();
        test_abort();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
